// File: rtl/me_pkg.sv
// Shared types and dimensions for the motion-estimation feeder slice.
package me_pkg;

  localparam int unsigned MACRO_DIM  = 16;
  localparam int unsigned SEARCH_DIM = 48;
  localparam int unsigned NUM_CAND   = SEARCH_DIM - MACRO_DIM + 1;

  typedef logic [7:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CUR,
    SCAN,
    FLUSH,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/sw_row_slicer.sv
// Picks MACRO_DIM consecutive pixels starting at column x out of one
// search-window row.
module sw_row_slicer
  import me_pkg::*;
(
  input  pixel_t [SEARCH_DIM-1:0] row,
  input  logic   [5:0]            x,
  output pixel_t [MACRO_DIM-1:0]  pix
);

  // Per-output-pixel column select; x stays within 0..NUM_CAND-1 so x+i never exceeds 47.
  always_comb begin
    logic [5:0] col;
    col = '0;
    pix = '0;
    for (int unsigned i = 0; i < MACRO_DIM; i++) begin
      col    = x + 6'(i);
      pix[i] = row[col];
    end
  end

endmodule

// File: rtl/me_feeder.sv
// Sequencer that loads the current macroblock, then scans the search window
// column offset by column offset, streaming row beats to the ME stage.
module me_feeder
  import me_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            cur_rd,
  output logic [$clog2(MACRO_DIM)-1:0]    cur_addr,
  input  logic [8*MACRO_DIM-1:0]          cur_data,
  output logic                            sw_rd,
  output logic [$clog2(SEARCH_DIM)-1:0]   sw_addr,
  input  logic [8*SEARCH_DIM-1:0]         sw_data,
  output logic                            en_cpr,
  output pixel_t [MACRO_DIM-1:0]          pixel_cpr_out,
  output logic                            en_spr,
  output pixel_t [MACRO_DIM-1:0]          pixel_spr_out,
  output logic                            cand_valid,
  output logic [5:0]                      cand_x,
  output logic [5:0]                      cand_y
);

  localparam int unsigned CW = $clog2(MACRO_DIM);
  localparam int unsigned SW = $clog2(SEARCH_DIM);

  feeder_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    r_q, r_d;
  logic [5:0]    x_q, x_d;

  logic          en_cpr_q, en_spr_q;
  logic [5:0]    r_dly_q, x_dly_q;
  pixel_t [MACRO_DIM-1:0] cpr_hold_q, cpr_hold_d;
  pixel_t [MACRO_DIM-1:0] spr_hold_q, spr_hold_d;

  pixel_t [MACRO_DIM-1:0] cur_pix;
  pixel_t [MACRO_DIM-1:0] spr_pix;

  assign cur_pix = cur_data;

  sw_row_slicer u_slicer (
    .row (sw_data),
    .x   (x_dly_q),
    .pix (spr_pix)
  );

  // Next-state and counter update; counters return to zero on wrap so
  // addresses read as 0 whenever the matching strobe is low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    x_d     = x_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_CUR;
      end
      LOAD_CUR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MACRO_DIM - 1)) begin
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (r_q == 6'(SEARCH_DIM - 1)) begin
          r_d = '0;
          if (x_q == 6'(NUM_CAND - 1)) begin
            x_d     = '0;
            state_d = FLUSH;
          end else begin
            x_d = x_q + 1'b1;
          end
        end else begin
          r_d = r_q + 1'b1;
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs decoded from the registered state and counters.
  always_comb begin
    busy     = (state_q == LOAD_CUR) || (state_q == SCAN) || (state_q == FLUSH);
    done     = (state_q == DONE);
    cur_rd   = (state_q == LOAD_CUR);
    cur_addr = cnt_q;
    sw_rd    = (state_q == SCAN);
    sw_addr  = SW'(r_q);
  end

  // Output beat path: read data arrives one cycle after the strobe, so the
  // strobe, row and x are delayed to line up with it; pixels hold when idle.
  always_comb begin
    cpr_hold_d    = en_cpr_q ? cur_pix : cpr_hold_q;
    spr_hold_d    = en_spr_q ? spr_pix : spr_hold_q;
    en_cpr        = en_cpr_q;
    en_spr        = en_spr_q;
    pixel_cpr_out = cpr_hold_d;
    pixel_spr_out = spr_hold_d;
    cand_valid    = en_spr_q && (r_dly_q >= 6'(MACRO_DIM - 1));
    cand_x        = cand_valid ? x_dly_q : '0;
    cand_y        = cand_valid ? (r_dly_q - 6'(MACRO_DIM - 1)) : '0;
  end

  // State, counters and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      r_q        <= '0;
      x_q        <= '0;
      en_cpr_q   <= 1'b0;
      en_spr_q   <= 1'b0;
      r_dly_q    <= '0;
      x_dly_q    <= '0;
      cpr_hold_q <= '0;
      spr_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      x_q        <= x_d;
      en_cpr_q   <= cur_rd;
      en_spr_q   <= sw_rd;
      r_dly_q    <= r_q;
      x_dly_q    <= x_q;
      cpr_hold_q <= cpr_hold_d;
      spr_hold_q <= spr_hold_d;
    end
  end

endmodule

// File: tb/tb_me_feeder.sv
// Scoreboard bench for me_feeder: expected beats are queued when reads are
// issued and compared when the matching en_* beat appears.
module tb_me_feeder;
  import me_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic                   busy, done, cur_rd, sw_rd, en_cpr, en_spr, cand_valid;
  logic [3:0]             cur_addr;
  logic [5:0]             sw_addr, cand_x, cand_y;
  logic [8*MACRO_DIM-1:0] cur_data = '0;
  logic [8*SEARCH_DIM-1:0] sw_data = '0;
  logic [8*MACRO_DIM-1:0] pixel_cpr_out, pixel_spr_out;

  me_feeder dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .cur_rd(cur_rd), .cur_addr(cur_addr), .cur_data(cur_data),
    .sw_rd(sw_rd), .sw_addr(sw_addr), .sw_data(sw_data),
    .en_cpr(en_cpr), .pixel_cpr_out(pixel_cpr_out),
    .en_spr(en_spr), .pixel_spr_out(pixel_spr_out),
    .cand_valid(cand_valid), .cand_x(cand_x), .cand_y(cand_y)
  );

  always #5 clk = ~clk;

  int unsigned ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  int pat = 0;

  function automatic logic [7:0] sw_pix(input int r, input int c);
    return (pat == 1) ? 8'(c) : 8'(r + c);
  endfunction

  // Buffer models: registered read, data one cycle after the strobe.
  always @(posedge clk) begin
    if (cur_rd)
      for (int i = 0; i < 16; i++) cur_data[8*i +: 8] <= 8'(cur_addr);
    if (sw_rd)
      for (int c = 0; c < 48; c++) sw_data[8*c +: 8] <= sw_pix(int'(sw_addr), c);
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [127:0] pix;
    logic         cv;
    logic [5:0]   cx;
    logic [5:0]   cy;
  } beat_t;

  beat_t        spr_q[$];
  logic [127:0] cpr_q[$];

  bit scan_on = 0;
  int t0 = 0;
  int cur_n, cur_first, cpr_n, cpr_first, cpr_last;
  int rd_n, spr_n, spr_first, spr_last, cand_n, done_cyc;

  // Monitor: pops and compares delivered beats, then queues expectations for new reads.
  always @(negedge clk) begin
    int c;
    int xx, rr;
    beat_t b;
    logic [127:0] e;
    c = int'(ncyc) - t0;
    if (!cand_valid) chk("cand_zero", {cand_x, cand_y}, 12'd0);
    if (scan_on) begin
      if (c == 1) chk("busy_c1", busy, 1);
      if (en_cpr) begin
        if (cpr_q.size() == 0) chk("cpr_unexpected", 1, 0);
        else begin
          e = cpr_q.pop_front();
          chk("cpr_pix", pixel_cpr_out, e);
        end
        if (cpr_n == 0) cpr_first = c;
        cpr_last = c;
        cpr_n++;
      end
      if (en_spr) begin
        if (spr_q.size() == 0) chk("spr_unexpected", 1, 0);
        else begin
          b = spr_q.pop_front();
          chk("spr_pix", pixel_spr_out, b.pix);
          chk("cand_tag", {cand_valid, cand_x, cand_y}, {b.cv, b.cx, b.cy});
        end
        if (spr_n == 0) spr_first = c;
        spr_last = c;
        spr_n++;
        if (cand_valid) cand_n++;
      end
      if (c == 33)   chk("tag_c33",   {cand_valid, cand_x, cand_y}, {1'b1, 6'd0,  6'd0});
      if (c == 65)   chk("tag_c65",   {cand_valid, cand_x, cand_y}, {1'b1, 6'd0,  6'd32});
      if (c == 81)   chk("tag_c81",   {cand_valid, cand_x, cand_y}, {1'b1, 6'd1,  6'd0});
      if (c == 1601) chk("tag_c1601", {cand_valid, cand_x, cand_y}, {1'b1, 6'd32, 6'd32});
      if (cur_rd) begin
        if (cur_first < 0) cur_first = c;
        chk("cur_addr", cur_addr, cur_n);
        e = {16{8'(cur_n)}};
        cpr_q.push_back(e);
        cur_n++;
      end
      if (sw_rd) begin
        xx = rd_n / 48;
        rr = rd_n % 48;
        chk("sw_addr", sw_addr, rr);
        for (int i = 0; i < 16; i++) b.pix[8*i +: 8] = sw_pix(rr, xx + i);
        b.cv = (rr >= 15);
        b.cx = b.cv ? 6'(xx) : 6'd0;
        b.cy = b.cv ? 6'(rr - 15) : 6'd0;
        spr_q.push_back(b);
        rd_n++;
      end
      if (done) begin
        done_cyc = c;
        chk("busy_in_done", busy, 0);
        scan_on = 0;
      end
    end
  end

  task automatic begin_scan();
    start = 1'b1;
    t0 = int'(ncyc);
    cur_n = 0; cur_first = -1; cpr_n = 0; cpr_first = -1; cpr_last = -1;
    rd_n = 0; spr_n = 0; spr_first = -1; spr_last = -1; cand_n = 0; done_cyc = -1;
    cpr_q.delete();
    spr_q.delete();
    scan_on = 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cycle(input int k);
    while (int'(ncyc) - t0 < k) @(negedge clk);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000 && done_cyc < 0; i++) @(negedge clk);
    chk("done_seen", done_cyc >= 0, 1);
  endtask

  task automatic check_stats();
    chk("cur_rd_first", cur_first, 1);
    chk("cpr_count", cpr_n, 16);
    chk("cpr_first", cpr_first, 2);
    chk("cpr_last", cpr_last, 17);
    chk("sw_rd_count", rd_n, 1584);
    chk("spr_count", spr_n, 1584);
    chk("spr_first", spr_first, 18);
    chk("spr_last", spr_last, 1601);
    chk("cand_count", cand_n, 1089);
    chk("done_cycle", done_cyc, 1602);
    chk("queues_empty", cpr_q.size() + spr_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {busy, done, cur_rd, sw_rd, en_cpr, en_spr, cand_valid,
                        cur_addr, sw_addr, cand_x, cand_y}, '0);
    chk({tag, "_cpr"}, pixel_cpr_out, '0);
    chk({tag, "_spr"}, pixel_spr_out, '0);
  endtask

  initial begin
    // reset then idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check_zero("idle");
      @(negedge clk);
    end

    // nominal scan, search pixel = r+c
    pat = 0;
    begin_scan();
    wait_done();
    check_stats();
    repeat (3) @(negedge clk);

    // column-ramp row, plus start pulses while busy and on the done cycle
    pat = 1;
    begin_scan();
    wait_cycle(100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cycle(1602);
    start = 1'b1;
    @(negedge clk);
    check_stats();
    begin_scan();
    wait_done();
    check_stats();
    repeat (3) @(negedge clk);

    // reset mid-scan, then a fresh scan from cycle 510
    pat = 0;
    begin_scan();
    wait_cycle(500);
    rst = 1'b1;
    scan_on = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 501; k < 510; k++) begin
      check_zero("rst_mid");
      @(negedge clk);
    end
    cpr_q.delete();
    spr_q.delete();
    begin_scan();
    wait_done();
    check_stats();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
